if_stage: RTL and testbench

- Instruction-fetch stage of the MUSA core. It consumes what the EX stage produces.
- It holds the program counter and takes the redirect target (next_address) from EX on a taken branch or jump.
- It fetches from instruction memory over a req/ack handshake and hands instruction plus PC to decode with a valid/ready handshake.
- It also sources the sequential PC that EX sees as pc_in.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_stage_pc_reg.sv | 32 +++
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP word, default PC step.
// Imported by the fetch stage and its PC register.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP = 32'd4;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: synchronous active-low reset, load has priority over increment.
// The increment wraps modulo 2^32.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        incr,
  output logic [31:0] pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // PC update: reset, then redirect load, then sequential advance
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (incr) begin
      pc <= pc + STEP;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: req/ack fetch from instruction memory, valid/ready hand-off to decode,
// redirect from EX with squashing of an in-flight request (DROP state).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] next_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_seq
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  if_state_e   state_r;
  logic [31:0] pc_s;
  logic        transfer_s;
  logic        pc_incr_s;
  logic [31:0] fetch_addr_s;

  // Handshake strobes and the address any newly issued request will use
  always_comb begin
    transfer_s   = if_valid & id_ready & ~redirect;
    pc_incr_s    = 1'b0;
    fetch_addr_s = pc_s;
    if ((state_r == REQ) && imem_ack && !redirect) begin
      pc_incr_s = 1'b1;
    end else begin
      pc_incr_s = 1'b0;
    end
    if (redirect) begin
      fetch_addr_s = next_address;
    end else begin
      fetch_addr_s = pc_s;
    end
  end

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (redirect),
    .load_value (next_address),
    .incr       (pc_incr_s),
    .pc         (pc_s)
  );

  // Fetch FSM with registered memory and decode-side outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_valid    <= 1'b0;
      instruction <= NOP_WORD;
      pc_out      <= 32'h0000_0000;
      pc_seq      <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= fetch_addr_s;
          if_valid  <= 1'b0;
        end
        REQ: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              // Data for the old path is dropped; a fresh request goes straight out
              state_r   <= REQ;
              imem_addr <= next_address;
            end else begin
              state_r <= DROP;
            end
          end else if (imem_ack) begin
            state_r     <= HOLD;
            imem_req    <= 1'b0;
            instruction <= imem_data;
            pc_out      <= pc_s;
            pc_seq      <= pc_s + STEP;
            if_valid    <= 1'b1;
          end else begin
            state_r <= REQ;
          end
        end
        HOLD: begin
          if (redirect || transfer_s) begin
            state_r   <= REQ;
            if_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= fetch_addr_s;
          end else begin
            state_r <= HOLD;
          end
        end
        DROP: begin
          if_valid <= 1'b0;
          if (imem_ack) begin
            state_r   <= REQ;
            imem_addr <= fetch_addr_s;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r  <= IDLE;
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage against a transaction-level fetch model; two instances,
// one at RESET_PC=0 and one at RESET_PC=FFFF_FFFC to exercise PC wrap.
module tb_if_stage;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_seq;
    logic [31:0] pc;
    logic        squash;
  } exp_t;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] next_address = 32'h0;
  logic [31:0] imem_data = 32'h0;
  logic        id_ready = 1'b0;
  logic        ack0 = 1'b0, ack1 = 1'b0;
  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, instr0, instr1, pco0, pco1, pcs0, pcs1;

  exp_t m0, m1;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [31:0] q0[$];
  logic [31:0] qs0[$];
  logic [31:0] q1[$];

  always #5 clock = ~clock;

  if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
    .clock(clock), .reset(reset), .redirect(redirect), .next_address(next_address),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0), .imem_data(imem_data),
    .if_valid(valid0), .id_ready(id_ready), .instruction(instr0), .pc_out(pco0), .pc_seq(pcs0)
  );

  if_stage #(.RESET_PC(WRAP_PC), .PC_STEP(4)) u_wrap (
    .clock(clock), .reset(reset), .redirect(redirect), .next_address(next_address),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_data(imem_data),
    .if_valid(valid1), .id_ready(id_ready), .instruction(instr1), .pc_out(pco1), .pc_seq(pcs1)
  );

  // Fetch model: a request stays outstanding whenever no instruction is held for decode;
  // a redirect while a request is in flight marks that request's data as stale.
  function automatic exp_t ref_step(exp_t m, logic [31:0] rpc, logic rst, logic red,
                                    logic [31:0] na, logic ack, logic [31:0] data, logic rdy);
    exp_t n;
    logic live;
    n = m;
    if (!rst) begin
      n = '0;
      n.pc = rpc;
      n.addr = rpc;
      return n;
    end
    live = m.req & ~ack;
    if (m.req && ack) begin
      if (!m.squash && !red) begin
        n.instr = data;
        n.pc_out = m.addr;
        n.pc_seq = m.addr + 32'd4;
        n.valid = 1'b1;
        n.pc = m.addr + 32'd4;
      end
      n.squash = 1'b0;
    end
    if (red) begin
      n.pc = na;
      n.valid = 1'b0;
      if (live) n.squash = 1'b1;
    end else if (m.valid && rdy) begin
      n.valid = 1'b0;
    end
    if (!live) begin
      n.req = ~n.valid;
      if (!n.valid) n.addr = n.pc;
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("req",    32'(req0),    32'(m0.req));
    check_eq("addr",   addr0,        m0.addr);
    check_eq("valid",  32'(valid0),  32'(m0.valid));
    check_eq("instr",  instr0,       m0.instr);
    check_eq("pc_out", pco0,         m0.pc_out);
    check_eq("pc_seq", pcs0,         m0.pc_seq);
    check_eq("w_req",    32'(req1),   32'(m1.req));
    check_eq("w_addr",   addr1,       m1.addr);
    check_eq("w_valid",  32'(valid1), 32'(m1.valid));
    check_eq("w_instr",  instr1,      m1.instr);
    check_eq("w_pc_out", pco1,        m1.pc_out);
    check_eq("w_pc_seq", pcs1,        m1.pc_seq);
  endtask

  // One clock: ack is only offered while the model says a request is outstanding
  task automatic drive(input logic rst, input logic red, input logic [31:0] na,
                       input logic a0, input logic a1, input logic rdy);
    reset = rst;
    redirect = red;
    next_address = na;
    ack0 = a0 & m0.req;
    ack1 = a1 & m1.req;
    id_ready = rdy;
    imem_data = $urandom;
    @(posedge clock);
    m0 = ref_step(m0, 32'h0000_0000, rst, red, na, ack0, imem_data, rdy);
    m1 = ref_step(m1, WRAP_PC, rst, red, na, ack1, imem_data, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    m0 = '0;
    m1 = '0;
    // Reset, then zero-latency memory with decode always ready
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_eq("rst_addr", addr1, WRAP_PC);
    check_eq("rst_req", 32'(req0), 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (valid0) begin q0.push_back(pco0); qs0.push_back(pcs0); end
      if (valid1) q1.push_back(pco1);
    end
    check_eq("seq_count", 32'(q0.size()), 32'd3);
    check_eq("seq_pc0", q0[0], 32'h0);
    check_eq("seq_pc1", q0[1], 32'h4);
    check_eq("seq_pc2", q0[2], 32'h8);
    check_eq("seq_pcs2", qs0[2], 32'hC);
    check_eq("wrap_pc0", q1[0], WRAP_PC);
    check_eq("wrap_pc1", q1[1], 32'h0);

    // Slow memory and a stalled decode
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_eq("wait_addr", addr0, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_eq("hold_req", 32'(req0), 32'h0);
      check_eq("hold_pc", pco0, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("after_hold_addr", addr0, 32'h4);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("req8_addr", addr0, 32'h8);

    // Redirect while the request for 0x8 is pending
    drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("drop_addr", addr0, 32'h8);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_eq("drop_valid", 32'(valid0), 32'h0);
    check_eq("target_addr", addr0, 32'h100);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_eq("target_pc", pco0, 32'h100);

    // Redirect in HOLD with decode ready the same cycle
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    check_eq("hold_redir_valid", 32'(valid0), 32'h0);
    check_eq("hold_redir_addr", addr0, 32'h200);

    // Two redirects while dropping
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
    check_eq("drop2_addr", addr0, 32'h200);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_eq("last_redir_addr", addr0, 32'h400);

    // Reset with the request acked in the same cycle
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_eq("mid_rst_req", 32'(req0), 32'h0);
    check_eq("mid_rst_instr", instr0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("rel_addr", addr0, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_red;
      logic [31:0] r_na;
      r_rst = ($urandom_range(0, 99) != 0);
      r_red = ($urandom_range(0, 7) == 0);
      r_na  = ($urandom_range(0, 9) == 0) ? WRAP_PC : ($urandom & 32'hFFFF_FFFC);
      drive(r_rst, r_red, r_na, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
